// File: rtl/lfsr_gen_pkg.sv
// Shared types and default maximal-length tap table for the lfsr_gen family.
// Tap encoding: bit k set means polynomial term x^(k+1) is present.
package lfsr_gen_pkg;

    typedef enum logic {
        FIB = 1'b0,
        GAL = 1'b1
    } lfsr_mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } lfsr_fsm_e;

    localparam int unsigned MIN_WIDTH = 3;
    localparam int unsigned MAX_WIDTH = 32;

    // Maximal-length polynomials for every supported width
    function automatic logic [31:0] default_taps(input int unsigned width);
        logic [31:0] taps;
        taps = 32'h0000_0000;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control/seed/status bundle between the LFSR generator and its consumer.
// With LFSR_GEN_PARITY_EN defined, lfsr_out carries an extra parity MSB.
interface lfsr_gen_if
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 7
);
`ifdef LFSR_GEN_PARITY_EN
    localparam int unsigned OUT_W = WIDTH + 1;
`else
    localparam int unsigned OUT_W = WIDTH;
`endif

    logic             en;
    lfsr_mode_e       mode;
    logic             load_valid;
    logic [WIDTH-1:0] load_seed;
    logic             load_ready;
    logic [OUT_W-1:0] lfsr_out;
    logic             seed_err;
    logic             period_done;
    logic [WIDTH-1:0] period_len;

    modport master (
        output en, mode, load_valid, load_seed,
        input  load_ready, lfsr_out, seed_err, period_done, period_len
    );

    modport slave (
        input  en, mode, load_valid, load_seed,
        output load_ready, lfsr_out, seed_err, period_done, period_len
    );

endinterface

// File: rtl/lfsr_gen_step.sv
// Combinational next-state for one LFSR step, Fibonacci or Galois form.
module lfsr_gen_step
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state,
    input  lfsr_mode_e       mode,
    output logic [WIDTH-1:0] next_state
);

    logic [WIDTH-1:0] fib_c;
    logic [WIDTH-1:0] gal_mask_c;
    logic [WIDTH-1:0] gal_c;

    // Fibonacci: shift left, feed back parity of the tapped bits
    assign fib_c = {state[WIDTH-2:0], ^(state & TAPS)};

    // Galois: multiply by x, reduce by the polynomial when the MSB falls out
    assign gal_mask_c = state[WIDTH-1] ? {TAPS[WIDTH-2:0], 1'b1} : '0;
    assign gal_c      = {state[WIDTH-2:0], 1'b0} ^ gal_mask_c;

    assign next_state = (mode == GAL) ? gal_c : fib_c;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with seed-load handshake, lock-up guard and period meter.
// Optional parity MSB on lfsr_out is enabled by defining LFSR_GEN_PARITY_EN.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic      clk,
    input  logic      rst,
    lfsr_gen_if.slave bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    lfsr_fsm_e        fsm_q;
    lfsr_fsm_e        fsm_d;
    lfsr_mode_e       mode_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] period_len_q;
    logic             load_ready_q;
    logic             seed_err_q;
    logic             period_done_q;

    logic [WIDTH-1:0] next_state_c;
    logic [WIDTH-1:0] seed_c;
    logic [WIDTH-1:0] cnt_base_c;
    logic [WIDTH-1:0] cnt_inc_c;
    logic [WIDTH-1:0] start_ref_c;
    logic             accept_c;
    logic             step_c;
    logic             lockup_c;
    logic             mode_chg_c;
    logic             cnt_sat_c;

    lfsr_gen_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state      (state_q),
        .mode       (bus.mode),
        .next_state (next_state_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= RUN;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // HOLD is a single dead cycle after every accepted load
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            RUN:     if (accept_c) fsm_d = HOLD;
            HOLD:    fsm_d = RUN;
            default: fsm_d = RUN;
        endcase
    end

    always_comb begin
        accept_c   = 1'b0;
        step_c     = 1'b0;
        lockup_c   = (state_q == '0);
        mode_chg_c = (bus.mode != mode_q);
        unique case (fsm_q)
            RUN: begin
                accept_c = bus.load_valid & load_ready_q;
                step_c   = bus.en & ~accept_c & ~lockup_c;
            end
            HOLD:    begin end
            default: begin end
        endcase
    end

    // A mode change restarts the period measurement from the current state
    assign seed_c      = (bus.load_seed == '0) ? ONE : bus.load_seed;
    assign cnt_base_c  = mode_chg_c ? '0 : cnt_q;
    assign start_ref_c = mode_chg_c ? state_q : start_q;
    assign cnt_sat_c   = (cnt_base_c == CNT_MAX);
    assign cnt_inc_c   = cnt_base_c + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEED;
            start_q       <= SEED;
            cnt_q         <= '0;
            period_len_q  <= '0;
            period_done_q <= 1'b0;
            seed_err_q    <= 1'b0;
            load_ready_q  <= 1'b1;
            mode_q        <= FIB;
        end else begin
            period_done_q <= 1'b0;
            seed_err_q    <= 1'b0;
            load_ready_q  <= (fsm_d == RUN);
            mode_q        <= bus.mode;
            if (accept_c) begin
                state_q    <= seed_c;
                start_q    <= seed_c;
                cnt_q      <= '0;
                seed_err_q <= (bus.load_seed == '0);
            end else if (lockup_c) begin
                state_q <= SEED;
                cnt_q   <= '0;
            end else begin
                if (mode_chg_c) begin
                    start_q <= state_q;
                end
                if (step_c) begin
                    state_q <= next_state_c;
                    if (next_state_c == start_ref_c) begin
                        period_done_q <= 1'b1;
                        if (!cnt_sat_c) begin
                            period_len_q <= cnt_inc_c;
                        end
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_sat_c ? cnt_base_c : cnt_inc_c;
                    end
                end else begin
                    cnt_q <= cnt_base_c;
                end
            end
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.seed_err    = seed_err_q;
    assign bus.period_done = period_done_q;
    assign bus.period_len  = period_len_q;

`ifdef LFSR_GEN_PARITY_EN
    assign bus.lfsr_out = {~^state_q, state_q};
`else
    assign bus.lfsr_out = state_q;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen (WIDTH=7): directed vector table, hand sequences,
// and randomized traffic against a polynomial-arithmetic reference model.
module tb_lfsr_gen;
    import lfsr_gen_pkg::*;

    localparam int unsigned W      = 7;
    localparam int unsigned TAPS_I = 32'h60;
    localparam int unsigned POLY   = (TAPS_I << 1) | 1;
    localparam int unsigned MASK   = (1 << W) - 1;
    localparam int unsigned PMAX   = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    lfsr_gen_if #(.WIDTH(W)) bus ();

    lfsr_gen #(.WIDTH(W), .TAPS(7'h60), .SEED(7'h01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       en;
        logic       lv;
        logic [6:0] seed;
        logic [6:0] out;
        logic       ready;
        logic       serr;
    } vec_t;

    vec_t vecs [14];

    // reference model state
    int unsigned m_st, m_start, m_steps, m_len;
    bit          m_hold, m_prev_gal, m_serr, m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input lfsr_mode_e mode, input logic lv, input logic [6:0] seed);
        bus.en         = en;
        bus.mode       = mode;
        bus.load_valid = lv;
        bus.load_seed  = seed;
    endtask

    task automatic do_reset();
        drive(1'b0, FIB, 1'b0, 7'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_st = 1; m_start = 1; m_steps = 0; m_len = 0;
        m_hold = 0; m_prev_gal = 0; m_serr = 0; m_done = 0;
    endtask

    // Multiply-by-x over GF(2)[x]/p for Galois; shift with tap parity for Fibonacci
    function automatic int unsigned ref_next(input int unsigned s, input bit gal);
        int unsigned t;
        if (!gal) begin
            t = ((s << 1) & MASK) | ($countones(s & TAPS_I) % 2);
        end else begin
            t = s << 1;
            if ((t >> W) & 1) t = t ^ POLY;
        end
        return t & MASK;
    endfunction

    task automatic model_step(input bit en, input bit gal, input bit lv, input int unsigned seed);
        int unsigned nx;
        m_serr = 0;
        m_done = 0;
        if (!m_hold && lv) begin
            m_st    = (seed == 0) ? 1 : seed;
            m_start = m_st;
            m_steps = 0;
            m_serr  = (seed == 0);
            m_hold  = 1;
        end else begin
            if (gal != m_prev_gal) begin
                m_start = m_st;
                m_steps = 0;
            end
            if (!m_hold && en) begin
                nx   = ref_next(m_st, gal);
                m_st = nx;
                if (nx == m_start) begin
                    m_done = 1;
                    if (m_steps < PMAX) m_len = m_steps + 1;
                    m_steps = 0;
                end else if (m_steps < PMAX) begin
                    m_steps++;
                end
            end
            m_hold = 0;
        end
        m_prev_gal = gal;
    endtask

    initial begin
        int pulses;
        int cnt;
        bit found;

        vecs[0]  = '{1'b1, 1'b0, 7'h00, 7'h02, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 7'h00, 7'h04, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 7'h00, 7'h08, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 7'h00, 7'h10, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 7'h00, 7'h20, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 7'h00, 7'h41, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 7'h00, 7'h03, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 7'h55, 7'h55, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 7'h00, 7'h55, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 7'h00, 7'h01, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 7'h12, 7'h01, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 7'h12, 7'h12, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 7'h00, 7'h12, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 7'h00, 7'h24, 1'b1, 1'b0};

        do_reset();
        chk("reset_out", 32'(bus.lfsr_out[6:0]), 32'h01);
        chk("reset_ready", 32'(bus.load_ready), 32'h1);
        chk("reset_serr", 32'(bus.seed_err), 32'h0);
        chk("reset_done", 32'(bus.period_done), 32'h0);
        chk("reset_len", 32'(bus.period_len), 32'h0);
`ifdef LFSR_GEN_PARITY_EN
        chk("reset_parity", 32'(bus.lfsr_out[W]), 32'h0);
`endif

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].en, FIB, vecs[i].lv, vecs[i].seed);
            tick();
            chk($sformatf("vec%0d_out", i), 32'(bus.lfsr_out[6:0]), 32'(vecs[i].out));
            chk($sformatf("vec%0d_ready", i), 32'(bus.load_ready), 32'(vecs[i].ready));
            chk($sformatf("vec%0d_serr", i), 32'(bus.seed_err), 32'(vecs[i].serr));
        end

        // Fibonacci free-run over one full period from reset
        do_reset();
        pulses = 0;
        drive(1'b1, FIB, 1'b0, 7'h00);
        for (int i = 0; i < 126; i++) begin
            tick();
            if (bus.period_done) pulses++;
        end
        chk("fib_early_pulses", 32'(pulses), 32'h0);
        tick();
        chk("fib_done", 32'(bus.period_done), 32'h1);
        chk("fib_len", 32'(bus.period_len), 32'd127);
        chk("fib_wrap_out", 32'(bus.lfsr_out[6:0]), 32'h01);
        drive(1'b0, FIB, 1'b0, 7'h00);
        tick();
        chk("fib_done_single", 32'(bus.period_done), 32'h0);
        chk("fib_len_hold", 32'(bus.period_len), 32'd127);

        // Galois: load 0x40, one step, then run to wrap
        drive(1'b0, GAL, 1'b0, 7'h00);
        tick();
        drive(1'b0, GAL, 1'b1, 7'h40);
        tick();
        chk("gal_load_out", 32'(bus.lfsr_out[6:0]), 32'h40);
        drive(1'b0, GAL, 1'b0, 7'h00);
        tick();
        drive(1'b1, GAL, 1'b0, 7'h00);
        tick();
        chk("gal_step1", 32'(bus.lfsr_out[6:0]), 32'h41);
        found = 0;
        cnt = 1;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            cnt++;
            if (bus.period_done) found = 1;
        end
        chk("gal_done_seen", 32'(found), 32'h1);
        chk("gal_steps", 32'(cnt), 32'd127);
        chk("gal_len", 32'(bus.period_len), 32'd127);
        chk("gal_wrap_out", 32'(bus.lfsr_out[6:0]), 32'h40);

        // Reset while in HOLD
        drive(1'b0, GAL, 1'b1, 7'h33);
        tick();
        chk("hold_ready", 32'(bus.load_ready), 32'h0);
        drive(1'b0, FIB, 1'b0, 7'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hold_out", 32'(bus.lfsr_out[6:0]), 32'h01);
        chk("rst_hold_ready", 32'(bus.load_ready), 32'h1);
        chk("rst_hold_len", 32'(bus.period_len), 32'h0);

        // Randomized traffic: busy window then a quiet window where periods complete
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit en, gal, lv;
            int unsigned seed;
            en   = ($urandom_range(3, 0) != 0);
            lv   = (i < 2000) ? ($urandom_range(31, 0) == 0) : ($urandom_range(1023, 0) == 0);
            gal  = m_prev_gal;
            if ((i < 2000) ? ($urandom_range(63, 0) == 0) : ($urandom_range(2047, 0) == 0))
                gal = ~gal;
            seed = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(MASK, 0);
            drive(en, gal ? GAL : FIB, lv, 7'(seed));
            model_step(en, gal, lv, seed);
            tick();
            chk("rnd_out", 32'(bus.lfsr_out[6:0]), 32'(m_st));
            chk("rnd_ready", 32'(bus.load_ready), 32'(!m_hold));
            chk("rnd_serr", 32'(bus.seed_err), 32'(m_serr));
            chk("rnd_done", 32'(bus.period_done), 32'(m_done));
            chk("rnd_len", 32'(bus.period_len), 32'(m_len));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random sequence generator for the 7-bit LFSR-with-parity family. It is generalised to any width and tap polynomial, with selectable Fibonacci or Galois stepping, a step enable, and a runtime seed-load handshake. It also guards against the all-zero lock-up state and measures the sequence period. It sits next to the test-pattern and scrambler logic as their stimulus source.

## Interface
- `WIDTH`, 7: state width, 3..32.
- `TAPS`, 7'b1100000: polynomial, bit k set = term x^(k+1) present; bit WIDTH-1 must be set.
- `SEED`, 1: reset state, nonzero.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  advance one step this cycle.
- `mode`  in  1  0 = Fibonacci, 1 = Galois.
- `load_valid`  in  1  seed offer.
- `load_seed`  in  WIDTH  seed value.
- `load_ready`  out  1  seed accepted when valid & ready.
- `lfsr_out`  out  WIDTH (+1 with parity)  current state; MSB is parity when enabled.
- `seed_err`  out  1  one-cycle pulse: zero seed substituted.
- `period_done`  out  1  one-cycle pulse: sequence returned to start value.
- `period_len`  out  WIDTH  last measured period, in steps.

## Operation
- FSM `RUN`/`HOLD`.
  - Reset: state=SEED, FSM=RUN, counter=0, start=SEED; all pulse outputs and `period_len` are 0; `load_ready`=1.
- Fibonacci step: next = {state[WIDTH-2:0], ^(state & TAPS)}.
- Galois step: next = {state[WIDTH-2:0], 0} ^ (state[WIDTH-1] ? {TAPS[WIDTH-2:0], 1} : 0).
- Load (RUN, valid & ready): state <= load_seed, or 1 if load_seed==0 (then `seed_err` pulses); start <= loaded value; counter <= 0; FSM -> HOLD.
- HOLD lasts exactly one cycle:
  - `load_ready`=0.
  - `en` is ignored.
  - FSM returns to RUN.
- Load takes priority over `en` in the same cycle; the step is dropped.
- Lock-up guard: if state is ever 0, the next cycle forces state <= SEED. No step is taken and the counter is cleared.
- Period counter: increments on every taken step.
  - If next == start: `period_done` pulses the following cycle, `period_len` <= counter+1, counter <= 0.
  - The counter saturates at all-ones and `period_len` is not updated while saturated.
- `mode` change between cycles: the new mode applies to the next step. It also sets start <= current state and clears the counter.
- `rst` mid-HOLD or mid-period returns everything to reset values in the next cycle.

## Timing
- All outputs are registered.
- `lfsr_out` reflects a step or load one cycle after the enabling edge.
- Parity bit is combinational from registered state.
- `period_done` and `period_len` update on the same edge.
- Back-to-back loads are accepted at most every 2 cycles.

## Configuration
- `LFSR_GEN_PARITY_EN` defined: `lfsr_out` is WIDTH+1 bits, and `lfsr_out[WIDTH]` = ~^state (XNOR reduction).
- `LFSR_GEN_PARITY_EN` undefined: `lfsr_out` is WIDTH bits and there is no parity logic.

## Structure
- Package `lfsr_gen_pkg`:
  - `lfsr_mode_e` (FIB, GAL).
  - `lfsr_fsm_e` (RUN, HOLD).
  - Default tap constants for widths 3..32.
- Sub-module `lfsr_gen_step`: combinational next-state for both modes. The top holds the FSM, the guard and the counter.

## Test plan
- WIDTH=7, mode=0, reset then en=1 for 7 cycles -> `lfsr_out[6:0]` = 0x02, 0x04, 0x08, 0x10, 0x20, 0x41, 0x03. With parity, reset value 0x01 gives parity bit 0.
- Free-run 127 steps from reset -> `period_done` pulses once, `period_len`=127, state back to 0x01.
- mode=1, load 0x40, then 1 step -> state 0x41; free-run -> `period_len`=127.
- load_seed=0 -> state 0x01, `seed_err`=1 for one cycle, `load_ready`=0 for one cycle.
- load_valid and en together with seed 0x55 -> state 0x55 with no step; en during HOLD is ignored.
- `rst` asserted during HOLD -> next cycle state=SEED, `load_ready`=1, `period_len`=0.
